// File: rtl/veer_types.sv
// Shared types for the IFU branch-predictor update path.
package veer_types;

  typedef struct packed {
    logic [30:0] pc;
    logic [1:0]  hist;
    logic        ataken;
    logic        misp;
    logic [30:0] target;
  } bp_upd_pkt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BHT  = 2'd1,
    BTB  = 2'd2
  } bp_state_e;

endpackage

// File: rtl/ifu_bp_upd_fifo.sv
// Update queue with pointer wrap, tail-merge write port and clear.
module ifu_bp_upd_fifo
  import veer_types::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              merge,
  input  logic              pop,
  input  bp_upd_pkt_t       wdata,
  output bp_upd_pkt_t       head_c,
  output logic [IDX_W-1:0]  tail_idx_c,
  output logic              empty_c,
  output logic              full_c,
  output logic              single_c,
  output logic              nxt_empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, tail_ptr;
  bp_upd_pkt_t   mem_q [DEPTH];
  bp_upd_pkt_t   mem_d [DEPTH];

  always_comb begin
    tail_ptr    = wptr_q - PW'(1);
    head_c      = mem_q[rptr_q[AW-1:0]];
    tail_idx_c  = mem_q[tail_ptr[AW-1:0]].pc[IDX_W-1:0];
    empty_c     = (wptr_q == rptr_q);
    full_c      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    single_c    = ((wptr_q - rptr_q) == PW'(1));
  end

  // Merge rewrites the newest entry in place instead of allocating.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q[AW-1:0]] = wdata;
      wptr_d = wptr_q + PW'(1);
    end else if (merge) begin
      mem_d[tail_ptr[AW-1:0]] = wdata;
    end
    if (pop) rptr_d = rptr_q + PW'(1);
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end
    nxt_empty_c = (wptr_d == rptr_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/ifu_bp_upd_ctl.sv
// Drains resolved-branch updates into the BHT/BTB arrays: one BHT write,
// plus a BTB target write for taken mispredicts.
module ifu_bp_upd_ctl
  import veer_types::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_valid,
  input  bp_upd_pkt_t       upd_pkt,
  input  logic              freeze,
  input  logic              bp_inv,
  input  logic              wr_ready,
  output logic              wr_valid,
  output logic              wr_btb,
  output logic [IDX_W-1:0]  wr_index,
  output logic [1:0]        wr_hist,
  output logic [30:0]       wr_target,
  output logic              empty,
  output logic [7:0]        drop_cnt
);

  bp_state_e         state_q, state_d;
  logic              wr_valid_q, wr_valid_d, wr_btb_q, wr_btb_d;
  logic [IDX_W-1:0]  wr_index_q, wr_index_d;
  logic [1:0]        wr_hist_q, wr_hist_d;
  logic [30:0]       wr_target_q, wr_target_d;
  logic              empty_q, empty_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  bp_upd_pkt_t       head_c;
  logic [IDX_W-1:0]  tail_idx_c;
  logic              fifo_empty_c, fifo_full_c, fifo_single_c, fifo_nxt_empty_c;
  logic              pop, push, merge, drop, issuing, merge_hit;
  logic              unused_pc_c;

  assign unused_pc_c = ^{upd_pkt.pc[30:IDX_W], head_c.pc[30:IDX_W]};

  ifu_bp_upd_fifo #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clr         (bp_inv),
    .push        (push),
    .merge       (merge),
    .pop         (pop),
    .wdata       (upd_pkt),
    .head_c      (head_c),
    .tail_idx_c  (tail_idx_c),
    .empty_c     (fifo_empty_c),
    .full_c      (fifo_full_c),
    .single_c    (fifo_single_c),
    .nxt_empty_c (fifo_nxt_empty_c)
  );

  // Outputs are registered from the next state so they change with it.
  always_comb begin
    state_d     = state_q;
    wr_index_d  = wr_index_q;
    wr_hist_d   = wr_hist_q;
    wr_target_d = wr_target_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty_c && !freeze) begin
        state_d    = BHT;
        wr_index_d = head_c.pc[IDX_W-1:0];
        wr_hist_d  = head_c.hist;
      end
      BHT: if (wr_ready) begin
        if (head_c.misp && head_c.ataken) begin
          state_d     = BTB;
          wr_target_d = head_c.target;
        end else begin
          state_d = IDLE;
          pop     = 1'b1;
        end
      end
      BTB: if (wr_ready) begin
        state_d = IDLE;
        pop     = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // The head is in flight from the cycle it is selected, so never merge into it.
    issuing   = (state_q != IDLE) || (state_d == BHT);
    merge_hit = upd_valid && !fifo_empty_c && (tail_idx_c == upd_pkt.pc[IDX_W-1:0]) &&
                !(issuing && fifo_single_c);
    merge     = merge_hit && !bp_inv;
    push      = upd_valid && !merge_hit && (!fifo_full_c || pop) && !bp_inv;
    drop      = upd_valid && !merge_hit && fifo_full_c && !pop && !bp_inv;

    if (bp_inv) state_d = IDLE;

    wr_valid_d = (state_d != IDLE);
    wr_btb_d   = (state_d == BTB);
    empty_d    = fifo_nxt_empty_c && (state_d == IDLE);
    drop_cnt_d = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_valid_q  <= 1'b0;
      wr_btb_q    <= 1'b0;
      wr_index_q  <= '0;
      wr_hist_q   <= '0;
      wr_target_q <= '0;
      empty_q     <= 1'b1;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_valid_q  <= wr_valid_d;
      wr_btb_q    <= wr_btb_d;
      wr_index_q  <= wr_index_d;
      wr_hist_q   <= wr_hist_d;
      wr_target_q <= wr_target_d;
      empty_q     <= empty_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign wr_valid  = wr_valid_q;
  assign wr_btb    = wr_btb_q;
  assign wr_index  = wr_index_q;
  assign wr_hist   = wr_hist_q;
  assign wr_target = wr_target_q;
  assign empty     = empty_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
